// File: rtl/store_buffer.sv
// Write-back store buffer: queues CPU stores, retires them to data memory in
// cycles without a load, and forwards the youngest matching store to loads.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_en,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    output logic [15:0] ld_data,
    output logic        empty,
    output logic        full,
    output logic [15:0] address,
    output logic [15:0] mem_write_data,
    output logic        mem_write_en,
    input  logic [15:0] readData
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   addr_q [DEPTH];
    logic [15:0]   addr_d [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [15:0]   data_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          drain;
    logic          push;
    logic [AW-1:0] idx;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A push into a full buffer is only accepted when the head leaves this cycle.
    always_comb begin
        drain = !ld_en && !empty;
        push  = st_en && (!full || drain);
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) begin
            addr_d[tail_q] = st_addr;
            data_d[tail_q] = st_data;
            tail_d         = tail_q + AW'(1);
        end
        if (drain) begin
            head_d = head_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, drain};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        mem_write_en = drain;
        if (ld_en) begin
            address = ld_addr;
        end else if (drain) begin
            address = addr_q[head_q];
        end else begin
            address = '0;
        end
        mem_write_data = (ld_en || drain) ? data_q[head_q] : '0;
    end

    // Walk entries oldest to youngest from head so the youngest match wins.
    always_comb begin
        ld_data = readData;
        idx     = '0;
        if (ld_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = head_q + AW'(i);
                if ((CW'(i) < count_q) && (addr_q[idx] == ld_addr)) begin
                    ld_data = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a negedge-write memory model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        st_en;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        empty;
    logic        full;
    logic [15:0] address;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic [15:0] readData;

    logic [15:0] mem [0:1023] = '{default: '0};
    int          wc = 0;
    int          total = 0;
    int          bad = 0;
    int          base;
    logic [15:0] refm [4];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .st_en          (st_en),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .ld_en          (ld_en),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .empty          (empty),
        .full           (full),
        .address        (address),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .readData       (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two addresses carry fixed preset contents that are never written.
    always_comb begin
        if (address == 16'h0000)      readData = 16'h5A5A;
        else if (address == 16'h0300) readData = 16'h3333;
        else                          readData = mem[address[9:0]];
    end

    always @(negedge clk) begin
        if (mem_write_en) begin
            mem[address[9:0]] <= mem_write_data;
            wc <= wc + 1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next posedge, apply inputs, let logic settle.
    task automatic drive(input logic s, input logic [15:0] sa, input logic [15:0] sd,
                         input logic l, input logic [15:0] la);
        @(posedge clk);
        #1;
        st_en = s; st_addr = sa; st_data = sd; ld_en = l; ld_addr = la;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        st_en = 1'b0; st_addr = '0; st_data = '0; ld_en = 1'b0; ld_addr = '0;
        #2;
        chk("rst_empty", 16'(empty), 16'd1);
        chk("rst_full", 16'(full), 16'd0);
        chk("rst_we", 16'(mem_write_en), 16'd0);
        chk("rst_addr", address, 16'h0000);
        chk("rst_wdata", mem_write_data, 16'h0000);
        chk("rst_lddata", ld_data, 16'h5A5A);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset during the first drain cycle.
        base = wc;
        drive(1'b1, 16'h0040, 16'h0001, 1'b0, 16'h0);
        drive(1'b1, 16'h0041, 16'h0002, 1'b0, 16'h0);
        chk("mid_we_before", 16'(mem_write_en), 16'd1);
        chk("mid_addr_before", address, 16'h0040);
        rst = 1'b1;
        #1;
        chk("mid_we_rst", 16'(mem_write_en), 16'd0);
        chk("mid_empty_rst", 16'(empty), 16'd1);
        chk("mid_addr_rst", address, 16'h0000);
        idle();
        rst = 1'b0;
        idle();
        idle();
        chk("mid_no_writes", 16'(wc - base), 16'd0);
        chk("mid_mem40", mem[10'h040], 16'h0000);
        chk("mid_empty_after", 16'(empty), 16'd1);

        // Basic drain: no same-cycle bypass, write next cycle.
        drive(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
        chk("basic_no_bypass", 16'(mem_write_en), 16'd0);
        idle();
        chk("basic_we", 16'(mem_write_en), 16'd1);
        chk("basic_addr", address, 16'h0010);
        chk("basic_wdata", mem_write_data, 16'hBEEF);
        idle();
        chk("basic_empty", 16'(empty), 16'd1);
        chk("basic_mem", mem[10'h010], 16'hBEEF);
        chk("basic_idle_addr", address, 16'h0000);

        // Forwarding priority; simultaneous store+load ignores the entry being pushed.
        drive(1'b1, 16'h0005, 16'h1111, 1'b1, 16'h0005);
        chk("fwd_ignore_push", ld_data, 16'h0000);
        chk("fwd_we0", 16'(mem_write_en), 16'd0);
        drive(1'b1, 16'h0005, 16'h2222, 1'b1, 16'h0005);
        chk("fwd_one_entry", ld_data, 16'h1111);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0005);
        chk("fwd_youngest", ld_data, 16'h2222);
        chk("fwd_we_load", 16'(mem_write_en), 16'd0);
        chk("fwd_addr_load", address, 16'h0005);
        chk("fwd_two_pending", {14'd0, empty, full}, 16'd0);
        idle();
        chk("fwd_drain1", mem_write_data, 16'h1111);
        idle();
        chk("fwd_drain2", mem_write_data, 16'h2222);
        idle();
        chk("fwd_empty", 16'(empty), 16'd1);
        chk("fwd_mem", mem[10'h005], 16'h2222);

        // Loads block drain while filling to full.
        base = wc;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 1'b1, 16'h0300);
            chk("blk_we0", 16'(mem_write_en), 16'd0);
            chk("blk_lddata", ld_data, 16'h3333);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0102);
        chk("blk_full", 16'(full), 16'd1);
        chk("blk_fwd_full", ld_data, 16'hA002);
        chk("blk_we_full", 16'(mem_write_en), 16'd0);
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            chk("blk_order_addr", address, 16'h0100 + 16'(i));
            chk("blk_order_data", mem_write_data, 16'hA000 + 16'(i));
        end
        idle();
        chk("blk_empty", 16'(empty), 16'd1);
        chk("blk_writes", 16'(wc - base), 16'(DEPTH));
        chk("blk_mem103", mem[10'h103], 16'hA003);

        // Store while full: pop and push in the same cycle.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 16'h0200 + 16'(i), 16'hB000 + 16'(i), 1'b1, 16'h0300);
        end
        drive(1'b1, 16'h0020, 16'h0A0A, 1'b0, 16'h0);
        chk("fs_full", 16'(full), 16'd1);
        chk("fs_we", 16'(mem_write_en), 16'd1);
        chk("fs_addr", address, 16'h0200);
        idle();
        chk("fs_still_full", 16'(full), 16'd1);
        chk("fs_addr1", address, 16'h0201);
        idle();
        chk("fs_addr2", address, 16'h0202);
        idle();
        chk("fs_addr3", address, 16'h0203);
        idle();
        chk("fs_addr_new", address, 16'h0020);
        chk("fs_data_new", mem_write_data, 16'h0A0A);
        idle();
        chk("fs_empty", 16'(empty), 16'd1);
        chk("fs_mem20", mem[10'h020], 16'h0A0A);
        chk("fs_mem200", mem[10'h200], 16'hB000);

        // Wrap-around against an architectural memory model.
        for (int j = 0; j < 4; j++) refm[j] = 16'h0000;
        for (int k = 0; k < 3 * DEPTH + DEPTH * 3 / 2; k++) begin
            if (k % 3 == 2) begin
                drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0050 + 16'((k + 3) % 4));
                chk("wrap_load", ld_data, refm[(k + 3) % 4]);
            end else begin
                drive(1'b1, 16'h0050 + 16'(k % 4), 16'hC000 + 16'(k), 1'b0, 16'h0);
                refm[k % 4] = 16'hC000 + 16'(k);
            end
        end
        idle();
        idle();
        idle();
        chk("wrap_empty", 16'(empty), 16'd1);
        for (int j = 0; j < 4; j++) begin
            chk("wrap_mem", mem[10'h050 + 10'(j)], refm[j]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
